// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer: OFDM receive frame tracker feeding the demapper; optional gap watchdog enabled by RX_SEQ_WDOG_EN
module rx_frame_sequencer #(
  parameter int FFT_DEPTH   = 12,
  parameter int FFT_SIZE    = 1024,
  parameter int N_PREAM     = 2,
  parameter int FRAME_SIZE  = 50,
  parameter int GAP_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ival,
  input  logic                 isop,
  input  logic [FFT_DEPTH-1:0] subc_i,
  input  logic [FFT_DEPTH-1:0] subc_q,
  input  logic                 frame_start,
  input  logic                 cfg_wr,
  input  logic [2:0]           cfg_M,
  input  logic [3:0]           cfg_ss,
  output logic                 oval,
  output logic                 osop,
  output logic [FFT_DEPTH-1:0] osubc_i,
  output logic [FFT_DEPTH-1:0] osubc_q,
  output logic [6:0]           frame_counter,
  output logic                 enable,
  output logic [2:0]           index_M_out,
  output logic [3:0]           index_SS_out,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_len,
  output logic                 err_timeout
);
  typedef enum logic [1:0] {IDLE, ARMED, PREAM, DATA} state_t;
  localparam int SCW = $clog2(FFT_SIZE + 1);
  localparam logic [SCW-1:0] SC_FULL = SCW'(FFT_SIZE);
  localparam logic [6:0] SYM_LAST = 7'(FRAME_SIZE - 1);
  localparam logic [6:0] SYM_PREAM = 7'(N_PREAM);
  state_t state, state_nxt;
  logic [SCW-1:0] sc_cnt, sc_nxt;
  logic [6:0] sym_cnt, sym_nxt;
  logic [2:0] sh_m;
  logic [3:0] sh_ss;
  logic run, act, bad_len, accept, last, tmo;
  assign run = (state == PREAM) || (state == DATA);
  assign busy = run;
  assign enable = run;
`ifdef RX_SEQ_WDOG_EN
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  logic [GW-1:0] gap;
  assign tmo = run && !ival && (gap == GW'(GAP_TIMEOUT - 1));
  // Count consecutive idle cycles inside a frame; any sample clears it
  always_ff @(posedge clk) begin
    if (rst || !run || ival || tmo) gap <= '0;
    else gap <= gap + GW'(1);
  end
`else
  assign tmo = GAP_TIMEOUT < 0;
`endif
  // Frame activation, symbol length check, counter advance and next state
  always_comb begin
    act = ival && isop && ((state == ARMED) || (state == IDLE && frame_start));
    bad_len = run && ival && (isop ? sc_cnt != SC_FULL : sc_cnt == SC_FULL);
    accept = act || (run && ival && !bad_len);
    sc_nxt = isop ? SCW'(1) : sc_cnt + SCW'(1);
    sym_nxt = act ? 7'd0 : isop ? sym_cnt + 7'd1 : sym_cnt;
    last = accept && (sc_nxt == SC_FULL) && (sym_nxt == SYM_LAST);
    state_nxt = (state == IDLE && frame_start) ? ARMED : state;
    state_nxt = accept ? ((sym_nxt < SYM_PREAM) ? PREAM : DATA) : state_nxt;
    state_nxt = (last || bad_len || tmo) ? IDLE : state_nxt;
  end
  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // Counters, shadow/active config and the registered demapper interface
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_cnt <= '0;
      sym_cnt <= '0;
      sh_m <= '0;
      sh_ss <= '0;
      index_M_out <= '0;
      index_SS_out <= '0;
      frame_counter <= '0;
      oval <= 1'b0;
      osop <= 1'b0;
      osubc_i <= '0;
      osubc_q <= '0;
      frame_done <= 1'b0;
      err_len <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (cfg_wr) begin
        sh_m <= cfg_M;
        sh_ss <= cfg_ss;
      end
      if (act) begin
        index_M_out <= cfg_wr ? cfg_M : sh_m;
        index_SS_out <= cfg_wr ? cfg_ss : sh_ss;
      end
      if (accept) begin
        sc_cnt <= sc_nxt;
        sym_cnt <= sym_nxt;
        frame_counter <= sym_nxt;
      end
      oval <= accept;
      osop <= accept && isop;
      osubc_i <= accept ? subc_i : '0;
      osubc_q <= accept ? subc_q : '0;
      frame_done <= last;
      err_len <= bad_len;
      err_timeout <= tmo;
    end
  end
endmodule

// File: tb/tb_rx_frame_sequencer.sv
// tb_rx_frame_sequencer: vector table plus directed frame sequences for rx_frame_sequencer
module tb_rx_frame_sequencer;
  localparam int FS = 16;
  localparam int NSYM = 50;
  localparam int GAP = 4096;
`ifdef RX_SEQ_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ival = 1'b0, isop = 1'b0, frame_start = 1'b0, cfg_wr = 1'b0;
  logic [11:0] subc_i = '0, subc_q = '0;
  logic [2:0] cfg_M = '0;
  logic [3:0] cfg_ss = '0;
  logic oval, osop, enable, busy, frame_done, err_len, err_timeout;
  logic [11:0] osubc_i, osubc_q;
  logic [6:0] frame_counter;
  logic [2:0] index_M_out;
  logic [3:0] index_SS_out;
  int checks = 0, errors = 0;
  int n_oval = 0, n_done = 0, n_errlen = 0, n_tmo = 0, n_zero_bad = 0, sop_idx = 0;
  bit mon_fc = 1'b0;
  typedef struct {
    logic r, v, s, fs, wr;
    logic [2:0] m;
    logic [3:0] ss;
    logic [11:0] di, dq;
    logic e_v, e_s;
    logic [6:0] e_fc;
    logic [2:0] e_m;
    logic [3:0] e_ss;
    logic e_busy;
    logic [11:0] e_di, e_dq;
    logic e_err;
  } vec_t;
  vec_t tbl [12];

  rx_frame_sequencer #(.FFT_DEPTH(12), .FFT_SIZE(FS), .N_PREAM(2), .FRAME_SIZE(NSYM), .GAP_TIMEOUT(GAP)) dut (
    .clk(clk), .rst(rst), .ival(ival), .isop(isop), .subc_i(subc_i), .subc_q(subc_q),
    .frame_start(frame_start), .cfg_wr(cfg_wr), .cfg_M(cfg_M), .cfg_ss(cfg_ss),
    .oval(oval), .osop(osop), .osubc_i(osubc_i), .osubc_q(osubc_q), .frame_counter(frame_counter),
    .enable(enable), .index_M_out(index_M_out), .index_SS_out(index_SS_out), .busy(busy),
    .frame_done(frame_done), .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ival = 1'b0;
    isop = 1'b0;
    frame_start = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic samp(input logic sop, input logic fs, input logic [11:0] d);
    ival = 1'b1;
    isop = sop;
    frame_start = fs;
    subc_i = d;
    subc_q = ~d;
    tick();
  endtask

  task automatic send_sym(input int sym, input int len, input logic fs);
    for (int j = 0; j < len; j++) samp(j == 0, fs && j == 0, 12'(sym * FS + j));
  endtask

  task automatic clear_counts();
    n_oval = 0;
    n_done = 0;
    n_errlen = 0;
    n_tmo = 0;
  endtask

  task automatic arm();
    frame_start = 1'b1;
    ival = 1'b0;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic run_frame();
    arm();
    sop_idx = 0;
    mon_fc = 1'b1;
    for (int s = 0; s < NSYM; s++) send_sym(s, FS, 1'b0);
    mon_fc = 1'b0;
    idle(3);
  endtask

  // Output monitor sampling away from the active edge
  always @(negedge clk) begin
    if (oval) n_oval++;
    if (frame_done) n_done++;
    if (err_len) n_errlen++;
    if (err_timeout) n_tmo++;
    if (oval === 1'b0 && (osubc_i !== '0 || osubc_q !== '0)) n_zero_bad++;
    if (mon_fc && oval && osop) begin
      chk($sformatf("fc_at_sop%0d", sop_idx), frame_counter, sop_idx);
      sop_idx++;
    end
  end

  initial begin
    tbl[0]  = '{1,0,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0,0};
    tbl[1]  = '{0,1,1,0,0,0,0,'h11,'h22,  0,0,0,0,0,0,0,0,0};
    tbl[2]  = '{0,0,0,0,1,3,1,0,0,        0,0,0,0,0,0,0,0,0};
    tbl[3]  = '{0,0,0,1,0,0,0,0,0,        0,0,0,0,0,0,0,0,0};
    tbl[4]  = '{0,1,0,0,0,0,0,7,8,        0,0,0,0,0,0,0,0,0};
    tbl[5]  = '{0,1,1,0,1,6,2,9,'hA,      1,1,0,6,2,1,9,'hA,0};
    tbl[6]  = '{0,1,0,0,0,0,0,'h10,'h20,  1,0,0,6,2,1,'h10,'h20,0};
    tbl[7]  = '{0,0,0,0,0,0,0,'h55,'h66,  0,0,0,6,2,1,0,0,0};
    tbl[8]  = '{0,1,1,0,0,0,0,3,4,        0,0,0,6,2,0,0,0,1};
    tbl[9]  = '{0,0,0,0,0,0,0,0,0,        0,0,0,6,2,0,0,0,0};
    tbl[10] = '{0,1,1,1,0,0,0,5,6,        1,1,0,6,2,1,5,6,0};
    tbl[11] = '{1,1,1,0,0,0,0,1,1,        0,0,0,0,0,0,0,0,0};
    tick();
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].r; ival = tbl[i].v; isop = tbl[i].s; frame_start = tbl[i].fs;
      cfg_wr = tbl[i].wr; cfg_M = tbl[i].m; cfg_ss = tbl[i].ss;
      subc_i = tbl[i].di; subc_q = tbl[i].dq;
      tick();
      chk($sformatf("v%0d_oval", i), oval, tbl[i].e_v);
      chk($sformatf("v%0d_osop", i), osop, tbl[i].e_s);
      chk($sformatf("v%0d_fc", i), frame_counter, tbl[i].e_fc);
      chk($sformatf("v%0d_M", i), index_M_out, tbl[i].e_m);
      chk($sformatf("v%0d_SS", i), index_SS_out, tbl[i].e_ss);
      chk($sformatf("v%0d_busy", i), {enable, busy}, {2{tbl[i].e_busy}});
      chk($sformatf("v%0d_osubc_i", i), osubc_i, tbl[i].e_di);
      chk($sformatf("v%0d_osubc_q", i), osubc_q, tbl[i].e_dq);
      chk($sformatf("v%0d_err_len", i), err_len, tbl[i].e_err);
    end
    rst = 1'b0;
    cfg_wr = 1'b0;
    idle(2);
    // normal frame with M=3, SS=1 configured up front
    cfg_wr = 1'b1; cfg_M = 3'd3; cfg_ss = 4'd1;
    tick();
    cfg_wr = 1'b0;
    clear_counts();
    run_frame();
    chk("norm_sops", sop_idx, NSYM);
    chk("norm_oval_cnt", n_oval, NSYM * FS);
    chk("norm_done", n_done, 1);
    chk("norm_errlen", n_errlen, 0);
    chk("norm_M", index_M_out, 3);
    chk("norm_SS", index_SS_out, 1);
    chk("norm_busy", busy, 0);
    samp(1'b1, 1'b0, 12'h0AA);
    chk("norm_idle_drop", oval, 0);
    idle(2);
    // short symbol 5 then a clean frame
    clear_counts();
    arm();
    for (int s = 0; s < 5; s++) send_sym(s, FS, 1'b0);
    send_sym(5, 10, 1'b0);
    samp(1'b1, 1'b0, 12'h0BB);
    chk("short_oval_on_bad", oval, 0);
    idle(3);
    chk("short_errlen", n_errlen, 1);
    chk("short_busy", busy, 0);
    chk("short_done", n_done, 0);
    chk("short_oval_cnt", n_oval, 5 * FS + 10);
    clear_counts();
    run_frame();
    chk("clean_done", n_done, 1);
    chk("clean_errlen", n_errlen, 0);
    chk("clean_oval_cnt", n_oval, NSYM * FS);
    // config written mid-frame applies only to the next frame
    arm();
    for (int s = 0; s < NSYM; s++) begin
      if (s == 10) begin
        cfg_wr = 1'b1; cfg_M = 3'd5; cfg_ss = 4'd7;
      end
      send_sym(s, FS, 1'b0);
      if (s == 10) begin
        cfg_wr = 1'b0;
        chk("mid_M_held", index_M_out, 3);
      end
    end
    idle(2);
    chk("mid_M_end", index_M_out, 3);
    chk("mid_SS_end", index_SS_out, 1);
    // frame_start together with the first isop
    clear_counts();
    samp(1'b1, 1'b1, 12'h123);
    chk("sim_oval", oval, 1);
    chk("sim_osop", osop, 1);
    chk("sim_fc", frame_counter, 0);
    chk("sim_data", osubc_i, 12'h123);
    chk("sim_M", index_M_out, 5);
    chk("sim_SS", index_SS_out, 7);
    chk("sim_busy", busy, 1);
    for (int j = 1; j < FS; j++) samp(1'b0, 1'b0, 12'(j));
    for (int s = 1; s < NSYM; s++) send_sym(s, FS, 1'b0);
    idle(3);
    chk("sim_done", n_done, 1);
    chk("sim_oval_cnt", n_oval, NSYM * FS);
    // reset in symbol 20
    arm();
    for (int s = 0; s < 20; s++) send_sym(s, FS, 1'b0);
    send_sym(20, 5, 1'b0);
    clear_counts();
    rst = 1'b1;
    samp(1'b0, 1'b0, 12'hFFF);
    chk("rst_oval", {oval, osop}, 0);
    chk("rst_data", {osubc_i, osubc_q}, 0);
    chk("rst_fc", frame_counter, 0);
    chk("rst_cfg", {index_M_out, index_SS_out}, 0);
    chk("rst_busy", {busy, enable}, 0);
    chk("rst_pulses", {frame_done, err_len, err_timeout}, 0);
    rst = 1'b0;
    idle(3);
    chk("rst_no_done", n_done, 0);
    chk("rst_no_err", n_errlen + n_tmo, 0);
    samp(1'b1, 1'b1, 12'h001);
    chk("rst_shadow_M", index_M_out, 0);
    chk("rst_shadow_SS", index_SS_out, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    // long ival stall in DATA
    clear_counts();
    arm();
    for (int s = 0; s < 5; s++) send_sym(s, FS, 1'b0);
    send_sym(5, 8, 1'b0);
    idle(GAP + 4);
    chk("stall_tmo", n_tmo, WD ? 1 : 0);
    chk("stall_busy", busy, WD ? 0 : 1);
    for (int j = 8; j < FS; j++) samp(1'b0, 1'b0, 12'(j));
    for (int s = 6; s < NSYM; s++) send_sym(s, FS, 1'b0);
    idle(3);
    chk("stall_done", n_done, WD ? 0 : 1);
    chk("stall_errlen", n_errlen, 0);
    chk("osubc_zero_idle", n_zero_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
